// File: rtl/instrumented_adder_pkg.sv
// Shared types and constants for the instrumented adder measurement sequencer.
package instrumented_adder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned SYNC_STAGES  = 2;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/instrumented_adder_meas_edge_sync_counter.sv
// Synchronises an asynchronous ring output, detects rising edges and counts
// them into a saturating counter with synchronous clear and count enable.
module edge_sync_counter
    import instrumented_adder_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   sat_q, sat_d;
    logic                   rise;

    assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        edge_d  = sync_q[SYNC_STAGES-1];
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (en && rise) begin
            // Count sticks at all-ones; the flag marks that the ceiling was reached.
            if (count_q != '1) begin
                count_d = count_q + CNT_W'(1);
            end
            if (count_d == '1) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            edge_q  <= 1'b0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            edge_q  <= edge_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/instrumented_adder_meas.sv
// Measurement sequencer: loads operands into an adder bank, checks the selected
// sum, then gates the selected ring oscillator and counts its edges.
module instrumented_adder_meas
    import instrumented_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned GATE_W = 16,
    parameter int unsigned SETTLE = 4
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_n_i,
    input  logic                      start_i,
    input  logic                      cont_i,
    input  logic [sel_width(N_CH)-1:0] ch_sel_i,
    input  logic [GATE_W-1:0]         gate_i,
    input  logic [WIDTH-1:0]          a_i,
    input  logic [WIDTH-1:0]          b_i,
    output logic [WIDTH-1:0]          adder_a_o,
    output logic [WIDTH-1:0]          adder_b_o,
    output logic [N_CH-1:0]           ring_en_o,
    input  logic [N_CH-1:0]           chain_i,
    input  logic [N_CH*WIDTH-1:0]     sum_i,
    output logic [WIDTH-1:0]          sum_o,
    output logic                      sum_err_o,
    output logic [CNT_W-1:0]          count_o,
    output logic                      sat_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int unsigned SEL_W = sel_width(N_CH);
    localparam int unsigned TMR_W = max3(GATE_W, $clog2(SETTLE + 1), $clog2(DRAIN_CYCLES + 1));

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [WIDTH-1:0]  lat_a_q, lat_a_d, lat_b_q, lat_b_d;
    logic [SEL_W-1:0]  lat_ch_q, lat_ch_d;
    logic [GATE_W-1:0] lat_gate_q, lat_gate_d;
    logic [WIDTH-1:0]  adder_a_q, adder_a_d, adder_b_q, adder_b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              sum_err_q, sum_err_d;

    logic [WIDTH-1:0]  sel_sum;
    logic              sel_chain;
    logic [N_CH-1:0]   ring_en;
    logic              cnt_clr, cnt_en;

    // Ring enable decodes straight from the state flop so an async reset drops it at once.
    always_comb begin
        sel_sum   = sum_i[WIDTH-1:0];
        sel_chain = chain_i[0];
        ring_en   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (lat_ch_q == SEL_W'(k)) begin
                sel_sum   = sum_i[k*WIDTH +: WIDTH];
                sel_chain = chain_i[k];
                ring_en[k] = (state_q == ST_RUN);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        lat_a_d    = lat_a_q;
        lat_b_d    = lat_b_q;
        lat_ch_d   = lat_ch_q;
        lat_gate_d = lat_gate_q;
        adder_a_d  = adder_a_q;
        adder_b_d  = adder_b_q;
        sum_d      = sum_q;
        sum_err_d  = sum_err_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    lat_a_d    = a_i;
                    lat_b_d    = b_i;
                    lat_ch_d   = (int'(ch_sel_i) < int'(N_CH)) ? ch_sel_i : '0;
                    lat_gate_d = gate_i;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                adder_a_d = lat_a_q;
                adder_b_d = lat_b_q;
                timer_d   = TMR_W'(SETTLE - 1);
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (timer_q == '0) state_d = ST_CHECK;
                else               timer_d = timer_q - TMR_W'(1);
            end
            ST_CHECK: begin
                sum_d     = sel_sum;
                sum_err_d = (sel_sum != (adder_a_q + adder_b_q));
                cnt_clr   = 1'b1;
                if (lat_gate_q == '0) begin
                    timer_d = TMR_W'(DRAIN_CYCLES - 1);
                    state_d = ST_DRAIN;
                end else begin
                    timer_d = TMR_W'(lat_gate_q) - TMR_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (timer_q == '0) begin
                    timer_d = TMR_W'(DRAIN_CYCLES - 1);
                    state_d = ST_DRAIN;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_DRAIN: begin
                cnt_en = 1'b1;
                if (timer_q == '0) state_d = ST_DONE;
                else               timer_d = timer_q - TMR_W'(1);
            end
            ST_DONE: begin
                state_d = cont_i ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            lat_a_q    <= '0;
            lat_b_q    <= '0;
            lat_ch_q   <= '0;
            lat_gate_q <= '0;
            adder_a_q  <= '0;
            adder_b_q  <= '0;
            sum_q      <= '0;
            sum_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            lat_a_q    <= lat_a_d;
            lat_b_q    <= lat_b_d;
            lat_ch_q   <= lat_ch_d;
            lat_gate_q <= lat_gate_d;
            adder_a_q  <= adder_a_d;
            adder_b_q  <= adder_b_d;
            sum_q      <= sum_d;
            sum_err_q  <= sum_err_d;
        end
    end

    edge_sync_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .din    (sel_chain),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .count_o(count_o),
        .sat_o  (sat_o)
    );

    assign adder_a_o = adder_a_q;
    assign adder_b_o = adder_b_q;
    assign ring_en_o = ring_en;
    assign sum_o     = sum_q;
    assign sum_err_o = sum_err_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_DONE);

endmodule

// File: tb/tb_instrumented_adder_meas.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks each done_o.
module tb_instrumented_adder_meas;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned N_CH   = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned GATE_W = 16;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned CMAX   = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic                  cont = 1'b0;
    logic [1:0]            ch_sel = '0;
    logic [GATE_W-1:0]     gate = '0;
    logic [WIDTH-1:0]      a_in = '0;
    logic [WIDTH-1:0]      b_in = '0;
    logic [WIDTH-1:0]      adder_a, adder_b;
    logic [N_CH-1:0]       ring_en;
    logic [N_CH-1:0]       chain = '0;
    logic [N_CH*WIDTH-1:0] sum_bus;
    logic [WIDTH-1:0]      sum_out;
    logic                  sum_err;
    logic [CNT_W-1:0]      count;
    logic                  sat, busy, done;

    always #5 clk = ~clk;

    instrumented_adder_meas #(
        .WIDTH (WIDTH),
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .GATE_W(GATE_W),
        .SETTLE(SETTLE)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .start_i   (start),
        .cont_i    (cont),
        .ch_sel_i  (ch_sel),
        .gate_i    (gate),
        .a_i       (a_in),
        .b_i       (b_in),
        .adder_a_o (adder_a),
        .adder_b_o (adder_b),
        .ring_en_o (ring_en),
        .chain_i   (chain),
        .sum_i     (sum_bus),
        .sum_o     (sum_out),
        .sum_err_o (sum_err),
        .count_o   (count),
        .sat_o     (sat),
        .busy_o    (busy),
        .done_o    (done)
    );

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             err;
        int unsigned      cnt;
        logic             sat;
        int unsigned      ch;
        int unsigned      gate;
        longint unsigned  done_cyc;
        logic [WIDTH-1:0] a;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int unsigned      vectors = 0;
    int unsigned      miscompares = 0;
    longint unsigned  cyc = 0;
    int unsigned      period[N_CH];
    int unsigned      phase[N_CH];
    logic             fault_on = 1'b0;
    int unsigned      fault_ch = 0;
    logic [WIDTH-1:0] fault_val = '0;
    int unsigned      en_cycles = 0;
    logic             en_onehot_ok = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Adder bank: every channel sums correctly unless a fault overrides one slice.
    always_comb begin
        sum_bus = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            sum_bus[k*WIDTH +: WIDTH] = adder_a + adder_b;
            if (fault_on && fault_ch == k) sum_bus[k*WIDTH +: WIDTH] = fault_val;
        end
    end

    // Ring model: toggles every period[k] enabled cycles, rests low when disabled.
    always @(posedge clk) begin
        #1;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (!rst_n || !ring_en[k]) begin
                chain[k] = 1'b0;
                phase[k] = 0;
            end else begin
                phase[k]++;
                if (phase[k] >= period[k]) begin
                    chain[k] = ~chain[k];
                    phase[k] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            en_cycles    = 0;
            en_onehot_ok = 1'b1;
        end else begin
            if (ring_en != '0) begin
                en_cycles++;
                if (sb.size() == 0 || ring_en != (N_CH'(1) << sb[0].ch)) en_onehot_ok = 1'b0;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done_o=1 expected no pending run (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_cycle", cyc, mon_e.done_cyc);
                    chk("sum", sum_out, mon_e.sum);
                    chk("sum_err", sum_err, mon_e.err);
                    chk("count", count, mon_e.cnt);
                    chk("sat", sat, mon_e.sat);
                    chk("ring_cycles", en_cycles, mon_e.gate);
                    chk("ring_onehot", en_onehot_ok, 1);
                    chk("adder_a_hold", adder_a, mon_e.a);
                end
                en_cycles    = 0;
                en_onehot_ok = 1'b1;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && (sb.size() != 0 || busy); i++) @(negedge clk);
        chk("drain_queue", sb.size(), 0);
        chk("idle_after", busy, 0);
        sb.delete();
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] cs, input int unsigned g, input int unsigned p,
                         input logic fon, input int unsigned fch, input logic [WIDTH-1:0] fval,
                         input int unsigned runs, input logic poke);
        exp_t             e;
        int unsigned      eff, tog, rises, n;
        logic [WIDTH-1:0] ref_sum;
        wait_idle();
        eff = (cs < N_CH) ? cs : 0;
        period[eff] = p;
        fault_on  = fon;
        fault_ch  = fch;
        fault_val = fval;
        tog     = g / p;
        rises   = (tog + 1) / 2;
        ref_sum = a + b;
        e.sum   = (fon && fch == eff) ? fval : ref_sum;
        e.err   = (e.sum != ref_sum);
        e.cnt   = (rises > CMAX) ? CMAX : rises;
        e.sat   = (rises >= CMAX);
        e.ch    = eff;
        e.gate  = g;
        e.a     = a;
        @(negedge clk);
        a_in = a; b_in = b; ch_sel = cs; gate = GATE_W'(g);
        start = 1'b1;
        cont  = (runs > 1);
        for (int unsigned r = 0; r < runs; r++) begin
            e.done_cyc = cyc + (r + 1) * (SETTLE + g + 6);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start  = 1'b0;
        a_in   = $urandom;
        b_in   = $urandom;
        ch_sel = 2'($urandom_range(0, 3));
        gate   = GATE_W'($urandom);
        chk("busy_after_start", busy, 1);
        if (poke) begin
            repeat (20) @(posedge clk);
            #1 start = 1'b1;
            a_in = $urandom;
            repeat (2) @(posedge clk);
            #1 start = 1'b0;
        end
        if (runs > 1) begin
            n = 0;
            for (int i = 0; i < 5000 && n < runs - 1; i++) begin
                @(negedge clk);
                if (done) n++;
            end
            @(posedge clk); #1 cont = 1'b0;
        end
        wait_drain();
    endtask

    initial begin
        for (int unsigned k = 0; k < N_CH; k++) period[k] = 1;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ring_en", ring_en, 0);
        chk("rst_count", count, 0);
        chk("rst_sat", sat, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_sum_err", sum_err, 0);
        chk("rst_adder_a", adder_a, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(32'd5, 32'd7, 2'd2, 100, 4, 1'b0, 0, '0, 1, 1'b1);
        issue(32'hFFFF_FFFF, 32'd1, 2'd0, 10, 2, 1'b0, 0, '0, 1, 1'b0);
        issue(32'hFFFF_FFFF, 32'd1, 2'd0, 10, 2, 1'b1, 0, 32'h1, 1, 1'b0);
        issue(32'h1234, 32'h4321, 2'd1, 600, 1, 1'b0, 0, '0, 1, 1'b0);
        issue(32'h10, 32'h20, 2'd1, 508, 1, 1'b0, 0, '0, 1, 1'b0);
        issue(32'h10, 32'h20, 2'd1, 509, 1, 1'b0, 0, '0, 1, 1'b0);
        issue(32'h99, 32'h1, 2'd2, 0, 3, 1'b0, 0, '0, 1, 1'b0);
        issue(32'hABCD, 32'h1111, 2'd3, 40, 3, 1'b1, 1, 32'hDEAD, 1, 1'b0);
        issue(32'h777, 32'h888, 2'd1, 30, 2, 1'b0, 0, '0, 3, 1'b0);

        for (int i = 0; i < 20; i++) begin
            issue($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 300),
                  $urandom_range(1, 8), ($urandom_range(0, 3) == 0), $urandom_range(0, N_CH - 1),
                  $urandom, 1, 1'b0);
        end

        // Asynchronous reset while the ring of channel 1 is running.
        wait_idle();
        period[1] = 3;
        @(negedge clk);
        a_in = 32'h55; b_in = 32'h66; ch_sel = 2'd1; gate = GATE_W'(200); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 100 && ring_en == '0; i++) @(negedge clk);
        chk("ring_running", ring_en, 3'b010);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ring_en", ring_en, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_count", count, 0);
        chk("post_rst_sum", sum_out, 0);
        chk("post_rst_adder_a", adder_a, 0);

        issue(32'h3, 32'h4, 2'd0, 20, 1, 1'b0, 0, '0, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
